// File: rtl/picorv32_mem_model_if.sv
// Native picorv32 memory bus bundle: the core side (master) issues requests,
// the memory model (slave) answers with ready and read data.
interface picorv32_mem_model_if;
    logic        mem_valid;
    logic        mem_instr;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_la_read;
    logic [31:0] mem_la_addr;

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
               mem_la_read, mem_la_addr,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
               mem_la_read, mem_la_addr,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/picorv32_mem_model.sv
// RAM plus console/exit/cycle-counter peripherals for picorv32 benches, answering
// either through the zero-wait look-ahead path or a wait-state handshake FSM.
module picorv32_mem_model #(
    parameter int          MEM_WORDS    = 16384,
    parameter string       MEM_INIT     = "",
    parameter int          WAIT_CYCLES  = 0,
    parameter int          LA_READ      = 1,
    parameter logic [31:0] CONSOLE_ADDR = 32'h1000_0000,
    parameter logic [31:0] EXIT_ADDR    = 32'h1000_0004,
    parameter logic [31:0] CYCLE_ADDR   = 32'h1000_0008,
    parameter int          FIFO_DEPTH   = 16,
    parameter int          TRAP_HOLD    = 10
) (
    input  logic                 clk,
    input  logic                 resetn,
    picorv32_mem_model_if.slave  bus,
    input  logic                 trap_i,
    output logic                 con_valid_o,
    output logic [7:0]           con_data_o,
    input  logic                 con_ready_i,
    output logic                 con_overflow_o,
    output logic                 addr_err_o,
    output logic                 done_o,
    output logic [31:0]          exit_code_o
);

    localparam bit          LA_MODE   = (LA_READ == 1) && (WAIT_CYCLES == 0);
    localparam int          IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int          PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [31:0] RAM_BYTES = 32'(4 * MEM_WORDS);
    localparam logic [7:0]  WAIT_LOAD = 8'(WAIT_CYCLES);
    localparam logic [31:0] TRAP_LAST = 32'(TRAP_HOLD - 1);
    localparam logic [PTR_W:0] FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} StateT;

    logic [31:0]      ram [MEM_WORDS];
    logic [7:0]       fifoMem [FIFO_DEPTH];

    StateT            state_q, state_d;
    logic [7:0]       waitCnt_q, waitCnt_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       wstrb_q, wstrb_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
    logic [PTR_W:0]   fifoCount_q, fifoCount_d;
    logic             overflow_q, addrErr_q, done_q;
    logic             trapActive_q, trapSeen_q;
    logic [31:0]      trapCnt_q, cycleCnt_q, exitCode_q;

    logic             respReady;
    logic [31:0]      rdAddr, rdWord;
    logic [31:0]      xferAddr, xferWdata;
    logic [3:0]       xferWstrb;
    logic             xferReq, xferFire, isWrite, xferRam, xferMmio;
    logic             conWriteReq, fifoFull, fifoPop, canPush, fifoPush, exitWrite;
    logic             unusedSignals;

    // Idle handshake reads the live bus so zero-wait responses are ready one edge later
    always_comb begin
        if (LA_MODE)                rdAddr = bus.mem_la_addr;
        else if (state_q == S_IDLE) rdAddr = bus.mem_addr;
        else                        rdAddr = addr_q;
    end

    always_comb begin
        rdWord = '0;
        if (rdAddr < RAM_BYTES)          rdWord = ram[rdAddr[IDX_W+1:2]];
        else if (rdAddr == CONSOLE_ADDR) rdWord = 32'(fifoCount_q);
        else if (rdAddr == EXIT_ADDR)    rdWord = exitCode_q;
        else if (rdAddr == CYCLE_ADDR)   rdWord = cycleCnt_q;
    end

    always_comb begin
        xferAddr  = LA_MODE ? bus.mem_addr  : addr_q;
        xferWdata = LA_MODE ? bus.mem_wdata : wdata_q;
        xferWstrb = LA_MODE ? bus.mem_wstrb : wstrb_q;
        xferReq   = LA_MODE ? bus.mem_valid : (state_q == S_RESP);
    end

    assign isWrite     = |xferWstrb;
    assign xferRam     = xferAddr < RAM_BYTES;
    assign xferMmio    = (xferAddr == CONSOLE_ADDR) || (xferAddr == EXIT_ADDR) ||
                         (xferAddr == CYCLE_ADDR);
    assign conWriteReq = xferReq && isWrite && (xferAddr == CONSOLE_ADDR);
    assign fifoFull    = fifoCount_q == FIFO_FULL;
    assign fifoPop     = (fifoCount_q != '0) && con_ready_i;
    assign canPush     = !fifoFull || fifoPop;
    assign fifoPush    = conWriteReq && canPush;
    assign xferFire    = LA_MODE ? bus.mem_valid : respReady;
    assign exitWrite   = xferFire && isWrite && (xferAddr == EXIT_ADDR);

    always_comb begin
        state_d   = state_q;
        waitCnt_d = waitCnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        respReady = 1'b0;
        if (LA_MODE) begin
            if (bus.mem_la_read) rdata_d = rdWord;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.mem_valid) begin
                        addr_d    = bus.mem_addr;
                        wdata_d   = bus.mem_wdata;
                        wstrb_d   = bus.mem_wstrb;
                        waitCnt_d = WAIT_LOAD;
                        if (WAIT_LOAD == 8'd0) begin
                            state_d = S_RESP;
                            rdata_d = rdWord;
                        end else begin
                            state_d = S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (waitCnt_q <= 8'd1) begin
                        state_d = S_RESP;
                        rdata_d = rdWord;
                    end else begin
                        waitCnt_d = waitCnt_q - 8'd1;
                    end
                end
                S_RESP: begin
                    // A console write to a full FIFO parks here until the sink drains a slot
                    if (!conWriteReq || canPush) begin
                        respReady = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            waitCnt_q <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
        end
    end

    always_comb begin
        fifoCount_d = fifoCount_q + (PTR_W + 1)'(fifoPush) - (PTR_W + 1)'(fifoPop);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            fifoCount_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            if (fifoPush) begin
                fifoMem[wrPtr_q] <= xferWdata[7:0];
                wrPtr_q          <= wrPtr_q + 1'b1;
            end
            if (fifoPop) rdPtr_q <= rdPtr_q + 1'b1;
            fifoCount_q <= fifoCount_d;
            if (LA_MODE && conWriteReq && !canPush) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn && xferFire && isWrite && xferRam) begin
            for (int b = 0; b < 4; b++) begin
                if (xferWstrb[b]) ram[xferAddr[IDX_W+1:2]][8*b +: 8] <= xferWdata[8*b +: 8];
            end
        end
    end

    // An exit write in the same cycle as trap expiry wins because it is assigned last
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cycleCnt_q   <= '0;
            trapCnt_q    <= '0;
            trapActive_q <= 1'b0;
            trapSeen_q   <= 1'b0;
            done_q       <= 1'b0;
            exitCode_q   <= '0;
            addrErr_q    <= 1'b0;
        end else begin
            cycleCnt_q <= cycleCnt_q + 32'd1;
            if (xferFire && !xferRam && !xferMmio) addrErr_q <= 1'b1;
            if (trapActive_q) begin
                if (trapCnt_q == TRAP_LAST) begin
                    trapActive_q <= 1'b0;
                    done_q       <= 1'b1;
                    if (!done_q) exitCode_q <= 32'hDEAD_0001;
                end else begin
                    trapCnt_q <= trapCnt_q + 32'd1;
                end
            end else if (trap_i && !trapSeen_q) begin
                trapActive_q <= 1'b1;
                trapSeen_q   <= 1'b1;
                trapCnt_q    <= '0;
            end
            if (exitWrite) begin
                done_q <= 1'b1;
                if (!done_q) exitCode_q <= xferWdata;
            end
        end
    end

    assign bus.mem_ready  = resetn && (LA_MODE ? 1'b1 : respReady);
    assign bus.mem_rdata  = resetn ? rdata_q : 32'h0;
    assign con_valid_o    = resetn && (fifoCount_q != '0);
    assign con_data_o     = resetn ? fifoMem[rdPtr_q] : 8'h0;
    assign con_overflow_o = resetn && overflow_q;
    assign addr_err_o     = resetn && addrErr_q;
    assign done_o         = resetn && done_q;
    assign exit_code_o    = resetn ? exitCode_q : 32'h0;

    assign unusedSignals = bus.mem_instr;

endmodule

// File: tb/tb_picorv32_mem_model.sv
// Directed bench: one handshake-mode model (3 wait states) and one look-ahead model,
// both with a 4-entry console FIFO.
module tb_picorv32_mem_model;
    localparam logic [31:0] CONSOLE = 32'h1000_0000;
    localparam logic [31:0] EXITREG = 32'h1000_0004;
    localparam logic [31:0] CYCLE   = 32'h1000_0008;

    logic        clk;
    logic        resetnA, resetnB, trapA, trapB, conReadyA, conReadyB;
    logic        conValidA, conValidB, overflowA, overflowB;
    logic        addrErrA, addrErrB, doneA, doneB;
    logic [7:0]  conDataA, conDataB;
    logic [31:0] exitA, exitB;
    int          assertCount = 0;
    int          failCount   = 0;

    picorv32_mem_model_if busA ();
    picorv32_mem_model_if busB ();

    picorv32_mem_model #(
        .MEM_WORDS(1024), .WAIT_CYCLES(3), .LA_READ(1), .FIFO_DEPTH(4), .TRAP_HOLD(10)
    ) dutA (
        .clk(clk), .resetn(resetnA), .bus(busA), .trap_i(trapA),
        .con_valid_o(conValidA), .con_data_o(conDataA), .con_ready_i(conReadyA),
        .con_overflow_o(overflowA), .addr_err_o(addrErrA), .done_o(doneA),
        .exit_code_o(exitA)
    );

    picorv32_mem_model #(
        .MEM_WORDS(1024), .WAIT_CYCLES(0), .LA_READ(1), .FIFO_DEPTH(4), .TRAP_HOLD(10)
    ) dutB (
        .clk(clk), .resetn(resetnB), .bus(busB), .trap_i(trapB),
        .con_valid_o(conValidB), .con_data_o(conDataB), .con_ready_i(conReadyB),
        .con_overflow_o(overflowB), .addr_err_o(addrErrB), .done_o(doneB),
        .exit_code_o(exitB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit toB, input logic valid, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] wstrb);
        if (toB) begin
            busB.mem_valid = valid;
            busB.mem_addr  = addr;
            busB.mem_wdata = wdata;
            busB.mem_wstrb = wstrb;
        end else begin
            busA.mem_valid = valid;
            busA.mem_addr  = addr;
            busA.mem_wdata = wdata;
            busA.mem_wstrb = wstrb;
        end
    endtask

    // Full handshake on model A: ready must be seen 4 edges after acceptance and last one cycle
    task automatic hsAccess(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wstrb, output logic [31:0] rdata);
        int   lat;
        logic readyAfter;
        applyStimulus(1'b0, 1'b1, addr, wdata, wstrb);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (busA.mem_ready !== 1'b1 && lat < 50);
        rdata = busA.mem_rdata;
        tick();
        readyAfter = busA.mem_ready;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        checkOutput({tag, "_latency"}, 32'(lat), 32'd4);
        checkOutput({tag, "_readyPulse"}, {31'd0, readyAfter}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] rd, first;
        logic [39:0] helloBytes;
        logic [7:0]  got [5];
        int          n;
        logic        sawReady;

        helloBytes = 40'h48_65_6C_6C_6F;
        resetnA = 1'b0; resetnB = 1'b0;
        trapA = 1'b0; trapB = 1'b0;
        conReadyA = 1'b0; conReadyB = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        busA.mem_instr = 1'b0; busA.mem_la_read = 1'b0; busA.mem_la_addr = 32'h0;
        busB.mem_instr = 1'b0; busB.mem_la_read = 1'b0; busB.mem_la_addr = 32'h0;

        repeat (3) tick();
        checkOutput("rstA_flags", {27'd0, busA.mem_ready, conValidA, overflowA, addrErrA, doneA}, 32'd0);
        checkOutput("rstA_rdata", busA.mem_rdata, 32'd0);
        checkOutput("rstA_exit", exitA, 32'd0);
        checkOutput("rstB_ready", {31'd0, busB.mem_ready}, 32'd0);
        resetnA = 1'b1; resetnB = 1'b1;
        tick();
        checkOutput("postRstA_ready", {31'd0, busA.mem_ready}, 32'd0);
        checkOutput("postRstB_ready", {31'd0, busB.mem_ready}, 32'd1);

        // Handshake RAM write with partial strobes
        hsAccess("hsInit", 32'h100, 32'hFFFF_FFFF, 4'hF, rd);
        hsAccess("hsWrite", 32'h100, 32'hA5A5_1234, 4'b0011, rd);
        hsAccess("hsRead", 32'h100, 32'h0, 4'h0, rd);
        checkOutput("hsReadData", rd, 32'hFFFF_1234);

        // Two back-to-back cycle reads capture 5 edges apart
        hsAccess("cyc1", CYCLE, 32'h0, 4'h0, first);
        hsAccess("cyc2", CYCLE, 32'h0, 4'h0, rd);
        checkOutput("cycleDelta", rd - first, 32'd5);

        // Console backpressure on the handshake model
        for (int i = 0; i < 4; i++)
            hsAccess("hsCon", CONSOLE, {24'd0, helloBytes[8*(4-i) +: 8]}, 4'b0001, rd);
        applyStimulus(1'b0, 1'b1, CONSOLE, {24'd0, helloBytes[7:0]}, 4'b0001);
        sawReady = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (busA.mem_ready === 1'b1) sawReady = 1'b1;
        end
        checkOutput("hsConStall", {31'd0, sawReady}, 32'd0);
        checkOutput("hsConHead", {24'd0, conDataA}, 32'h48);
        conReadyA = 1'b1;
        #1;
        checkOutput("hsConRelease", {31'd0, busA.mem_ready}, 32'd1);
        n = 0;
        for (int i = 0; i < 20 && n < 5; i++) begin
            if (conValidA) begin
                got[n] = conDataA;
                n++;
            end
            tick();
            applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        end
        conReadyA = 1'b0;
        checkOutput("hsConCount", 32'(n), 32'd5);
        for (int i = 0; i < 5; i++)
            checkOutput("hsConByte", {24'd0, got[i]}, {24'd0, helloBytes[8*(4-i) +: 8]});
        checkOutput("hsConEmpty", {31'd0, conValidA}, 32'd0);
        checkOutput("hsConNoOverflow", {31'd0, overflowA}, 32'd0);

        // Exit write then trap: exit code must survive the trap
        checkOutput("exitDoneBefore", {31'd0, doneA}, 32'd0);
        hsAccess("exitWr", EXITREG, 32'h0000_002A, 4'hF, rd);
        checkOutput("exitDone", {31'd0, doneA}, 32'd1);
        checkOutput("exitCode", exitA, 32'h2A);
        trapA = 1'b1;
        tick();
        trapA = 1'b0;
        repeat (12) tick();
        hsAccess("exitWr2", EXITREG, 32'h0000_0055, 4'hF, rd);
        hsAccess("exitRd", EXITREG, 32'h0, 4'h0, rd);
        checkOutput("exitReadback", rd, 32'h2A);
        checkOutput("exitCodeKept", exitA, 32'h2A);

        // Reset in the middle of WAIT must abort the write
        hsAccess("rstSeed", 32'h40, 32'h1234_5678, 4'hF, rd);
        applyStimulus(1'b0, 1'b1, 32'h40, 32'hCAFE_F00D, 4'hF);
        tick();
        tick();
        resetnA = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        checkOutput("midRst_flags", {27'd0, busA.mem_ready, conValidA, overflowA, addrErrA, doneA}, 32'd0);
        checkOutput("midRst_exit", exitA, 32'd0);
        sawReady = 1'b0;
        tick();
        resetnA = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (busA.mem_ready === 1'b1) sawReady = 1'b1;
        end
        checkOutput("midRstNoReady", {31'd0, sawReady}, 32'd0);
        checkOutput("midRstDoneCleared", {31'd0, doneA}, 32'd0);
        hsAccess("rstRead", 32'h40, 32'h0, 4'h0, rd);
        checkOutput("midRstRamKept", rd, 32'h1234_5678);
        checkOutput("addrErrBefore", {31'd0, addrErrA}, 32'd0);
        hsAccess("badAddr", 32'h2000_0000, 32'h0, 4'h0, rd);
        checkOutput("badAddrData", rd, 32'd0);
        checkOutput("badAddrErr", {31'd0, addrErrA}, 32'd1);

        // Look-ahead model: write then registered look-ahead read
        applyStimulus(1'b1, 1'b1, 32'h8, 32'hDEAD_BEEF, 4'hF);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        checkOutput("laReadyWrite", {31'd0, busB.mem_ready}, 32'd1);
        busB.mem_la_read = 1'b1; busB.mem_la_addr = 32'h8;
        tick();
        busB.mem_la_read = 1'b0;
        checkOutput("laRead", busB.mem_rdata, 32'hDEAD_BEEF);
        checkOutput("laReadyRead", {31'd0, busB.mem_ready}, 32'd1);
        applyStimulus(1'b1, 1'b1, 32'h8, 32'h1122_3344, 4'b1010);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        busB.mem_la_read = 1'b1; busB.mem_la_addr = 32'h8;
        tick();
        checkOutput("laStrobeRead", busB.mem_rdata, 32'h11AD_33EF);
        busB.mem_la_addr = 32'h0800_0000;
        tick();
        busB.mem_la_read = 1'b0;
        checkOutput("laOutOfRange", busB.mem_rdata, 32'd0);

        // Look-ahead console: fifth byte is dropped
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b1, CONSOLE, {24'd0, helloBytes[8*(4-i) +: 8]}, 4'b0001);
            tick();
        end
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        checkOutput("laOverflow", {31'd0, overflowB}, 32'd1);
        checkOutput("laConHead", {24'd0, conDataB}, 32'h48);
        busB.mem_la_read = 1'b1; busB.mem_la_addr = CONSOLE;
        tick();
        busB.mem_la_read = 1'b0;
        checkOutput("laConCountRead", busB.mem_rdata, 32'd4);
        conReadyB = 1'b1;
        n = 0;
        for (int i = 0; i < 10 && n < 4; i++) begin
            if (conValidB) begin
                got[n] = conDataB;
                n++;
            end
            tick();
        end
        conReadyB = 1'b0;
        checkOutput("laDrainCount", 32'(n), 32'd4);
        for (int i = 0; i < 4; i++)
            checkOutput("laConByte", {24'd0, got[i]}, {24'd0, helloBytes[8*(4-i) +: 8]});
        checkOutput("laDrainEmpty", {31'd0, conValidB}, 32'd0);
        checkOutput("laOverflowSticky", {31'd0, overflowB}, 32'd1);

        // Trap-only completion after exactly 10 cycles
        checkOutput("trapDoneBefore", {31'd0, doneB}, 32'd0);
        trapB = 1'b1;
        tick();
        trapB = 1'b0;
        repeat (9) tick();
        checkOutput("trapDoneAt9", {31'd0, doneB}, 32'd0);
        tick();
        checkOutput("trapDoneAt10", {31'd0, doneB}, 32'd1);
        checkOutput("trapExitCode", exitB, 32'hDEAD_0001);
        checkOutput("trapReadyStill", {31'd0, busB.mem_ready}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
